// File: rtl/bsg_noc_link_loopback.sv
// Per-channel NoC link loopback: each channel either passes flits between router
// and external link, or buffers router output in a small FIFO and replays it back in.
module bsg_noc_link_loopback #(
  parameter int width_p       = 32,
  parameter int channels_p    = 5,
  parameter int els_p         = 4,
  parameter int count_width_p = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [channels_p-1:0]             mode_i,

  input  logic [channels_p-1:0]             router_v_i,
  input  logic [channels_p*width_p-1:0]     router_data_i,
  output logic [channels_p-1:0]             router_ready_and_o,

  output logic [channels_p-1:0]             router_v_o,
  output logic [channels_p*width_p-1:0]     router_data_o,
  input  logic [channels_p-1:0]             router_ready_and_i,

  input  logic [channels_p-1:0]             ext_v_i,
  input  logic [channels_p*width_p-1:0]     ext_data_i,
  output logic [channels_p-1:0]             ext_ready_and_o,

  output logic [channels_p-1:0]             ext_v_o,
  output logic [channels_p*width_p-1:0]     ext_data_o,
  input  logic [channels_p-1:0]             ext_ready_and_i,

  output logic [channels_p-1:0]             busy_o,
  output logic [channels_p*count_width_p-1:0] count_o
);

  localparam int ptrW = $clog2(els_p);

  typedef enum logic [1:0] {PASS, LOOP, DRAIN} state_e;

  for (genvar c = 0; c < channels_p; c++) begin : gCh
    state_e                   state_q, state_d;
    logic [ptrW:0]            wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [count_width_p-1:0] cnt_q, cnt_d;
    logic [width_p-1:0]       mem_q [els_p];
    logic                     full, empty, enq, deq;
    logic [width_p-1:0]       rInData, eInData, head;
    logic                     rvo, rrdyo, evo, erdyo;
    logic [width_p-1:0]       rdo, edo;

    assign rInData = router_data_i[c*width_p +: width_p];
    assign eInData = ext_data_i[c*width_p +: width_p];

    // Top pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[ptrW] != rdPtr_q[ptrW]) &&
                   (wrPtr_q[ptrW-1:0] == rdPtr_q[ptrW-1:0]);
    assign head  = mem_q[rdPtr_q[ptrW-1:0]];

    assign enq = (state_q == LOOP) && router_v_i[c] && !full;
    assign deq = (state_q != PASS) && !empty && router_ready_and_i[c];

    always_comb begin
      wrPtr_d = enq ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d = deq ? rdPtr_q + 1'b1 : rdPtr_q;
      cnt_d   = cnt_q;
      if (deq && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      state_d = state_q;
      // Leaving LOOP/DRAIN looks at post-edge occupancy so PASS is never entered with data.
      unique case (state_q)
        PASS:    if (mode_i[c]) state_d = LOOP;
        LOOP:    if (!mode_i[c]) state_d = (wrPtr_d == rdPtr_d) ? PASS : DRAIN;
        DRAIN: begin
          if (mode_i[c])                state_d = LOOP;
          else if (wrPtr_d == rdPtr_d)  state_d = PASS;
        end
        default: state_d = PASS;
      endcase
    end

    always_comb begin
      rvo   = ext_v_i[c];
      rdo   = eInData;
      erdyo = router_ready_and_i[c];
      evo   = router_v_i[c];
      edo   = rInData;
      rrdyo = ext_ready_and_i[c];
      if (state_q != PASS) begin
        rvo   = !empty;
        rdo   = head;
        erdyo = 1'b0;
        evo   = 1'b0;
        rrdyo = (state_q == LOOP) && !full;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        state_q <= PASS;
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        wrPtr_q <= wrPtr_d;
        rdPtr_q <= rdPtr_d;
        cnt_q   <= cnt_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (enq) mem_q[wrPtr_q[ptrW-1:0]] <= rInData;
    end

    assign router_v_o[c]                          = rvo;
    assign router_data_o[c*width_p +: width_p]    = rdo;
    assign ext_ready_and_o[c]                     = erdyo;
    assign ext_v_o[c]                             = evo;
    assign ext_data_o[c*width_p +: width_p]       = edo;
    assign router_ready_and_o[c]                  = rrdyo;
    assign busy_o[c]                              = (state_q != PASS);
    assign count_o[c*count_width_p +: count_width_p] = cnt_q;
  end

endmodule

// File: tb/tb_bsg_noc_link_loopback.sv
// Directed bench for bsg_noc_link_loopback: pass, loop order, full, drain,
// counter saturation and mid-loop reset, with channel 1 watched for isolation.
module tb_bsg_noc_link_loopback;

  localparam int W   = 32;
  localparam int CH  = 2;
  localparam int ELS = 4;
  localparam int CW  = 4;

  logic             clk;
  logic             resetN;
  logic [CH-1:0]    mode;
  logic [CH-1:0]    routerVI, routerReadyAndO, routerVO, routerReadyAndI;
  logic [CH*W-1:0]  routerDataI, routerDataO, extDataI, extDataO;
  logic [CH-1:0]    extVI, extReadyAndO, extVO, extReadyAndI;
  logic [CH-1:0]    busy;
  logic [CH*CW-1:0] countO;

  int vectors    = 0;
  int miscompares = 0;

  bsg_noc_link_loopback #(
    .width_p(W), .channels_p(CH), .els_p(ELS), .count_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(resetN), .mode_i(mode),
    .router_v_i(routerVI), .router_data_i(routerDataI), .router_ready_and_o(routerReadyAndO),
    .router_v_o(routerVO), .router_data_o(routerDataO), .router_ready_and_i(routerReadyAndI),
    .ext_v_i(extVI), .ext_data_i(extDataI), .ext_ready_and_o(extReadyAndO),
    .ext_v_o(extVO), .ext_data_o(extDataO), .ext_ready_and_i(extReadyAndI),
    .busy_o(busy), .count_o(countO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives channel 0 inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic m, input logic rv, input logic [W-1:0] rd,
                               input logic rrdy, input logic ev, input logic [W-1:0] ed,
                               input logic erdy);
    mode[0]            = m;
    routerVI[0]        = rv;
    routerDataI[W-1:0] = rd;
    routerReadyAndI[0] = rrdy;
    extVI[0]           = ev;
    extDataI[W-1:0]    = ed;
    extReadyAndI[0]    = erdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    mode = '0; routerVI = '0; routerDataI = '0; routerReadyAndI = '0;
    extVI = '0; extDataI = '0; extReadyAndI = '0;
    resetN = 1'b1;
    #1 resetN = 1'b0;
    #2;
    checkOutput("resetBusy",  32'(busy), 32'h0);
    checkOutput("resetCount", 32'(countO), 32'h0);
    checkOutput("resetRv",    32'(routerVO), 32'h0);
    #9 resetN = 1'b1;
    tick();

    // Pass mode on both channels, both directions
    extVI[1] = 1'b1; extDataI[2*W-1:W] = 32'h12345678; routerReadyAndI[1] = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("passExtV",    32'(extVO[0]), 32'h1);
    checkOutput("passExtData", extDataO[W-1:0], 32'hA5A5A5A5);
    checkOutput("passRrdy",    32'(routerReadyAndO[0]), 32'h1);
    checkOutput("passCh1Data", routerDataO[2*W-1:W], 32'h12345678);
    checkOutput("passCh1Erdy", 32'(extReadyAndO[1]), 32'h1);
    tick();
    checkOutput("passCount",   32'(countO), 32'h0);
    checkOutput("passBusy",    32'(busy), 32'h0);
    extVI[1] = 1'b0; routerReadyAndI[1] = 1'b0;

    // Loop: enqueue 1,2,3 and replay in order
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("loopBusy",   32'(busy[0]), 32'h1);
    checkOutput("loopRvEmpty", 32'(routerVO[0]), 32'h0);
    checkOutput("loopRrdy",   32'(routerReadyAndO[0]), 32'h1);
    checkOutput("loopExtV",   32'(extVO[0]), 32'h0);
    checkOutput("loopExtRdy", 32'(extReadyAndO[0]), 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("loopLatencyV", 32'(routerVO[0]), 32'h1);
    checkOutput("loopOut1",     routerDataO[W-1:0], 32'h1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h3, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("loopOut2", routerDataO[W-1:0], 32'h2);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("loopOut3", routerDataO[W-1:0], 32'h3);
    tick();
    checkOutput("loopDrainedV", 32'(routerVO[0]), 32'h0);
    checkOutput("loopCount3",   32'(countO[CW-1:0]), 32'h3);
    checkOutput("isoCount1",    32'(countO[2*CW-1:CW]), 32'h0);
    checkOutput("isoBusy1",     32'(busy[1]), 32'h0);

    // Fill the FIFO with the router not accepting
    for (int i = 0; i < ELS; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(10 + i), 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("fillRrdy", 32'(routerReadyAndO[0]), 32'h1);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 32'd14, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("fullRrdy", 32'(routerReadyAndO[0]), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'd14, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("fullNoBypass", 32'(routerReadyAndO[0]), 32'h0);
    checkOutput("fullHead",     routerDataO[W-1:0], 32'd10);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("afterDeqRrdy", 32'(routerReadyAndO[0]), 32'h1);
    checkOutput("afterDeqHead", routerDataO[W-1:0], 32'd11);

    // Drain: leave two flits, drop mode
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'd20, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drainBusy",   32'(busy[0]), 32'h1);
    checkOutput("drainRrdy",   32'(routerReadyAndO[0]), 32'h0);
    checkOutput("drainExtV",   32'(extVO[0]), 32'h0);
    checkOutput("drainExtRdy", 32'(extReadyAndO[0]), 32'h0);
    checkOutput("drainHead1",  routerDataO[W-1:0], 32'd12);
    tick();
    checkOutput("drainBusy2",  32'(busy[0]), 32'h1);
    checkOutput("drainRrdy2",  32'(routerReadyAndO[0]), 32'h0);
    checkOutput("drainHead2",  routerDataO[W-1:0], 32'd13);
    tick();
    checkOutput("postDrainBusy", 32'(busy[0]), 32'h0);
    checkOutput("postDrainRrdy", 32'(routerReadyAndO[0]), 32'h1);
    checkOutput("postDrainExtV", 32'(extVO[0]), 32'h1);
    checkOutput("postDrainData", extDataO[W-1:0], 32'd20);
    checkOutput("countKept",     32'(countO[CW-1:0]), 32'h7);

    // Saturation: 20 more replays on a 4-bit counter
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(100 + i), 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("satCount", 32'(countO[CW-1:0]), 32'hF);
    checkOutput("satEmpty", 32'(routerVO[0]), 32'h0);

    // Reset with three flits buffered
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(30 + i), 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("preResetV",    32'(routerVO[0]), 32'h1);
    checkOutput("preResetHead", routerDataO[W-1:0], 32'd30);
    resetN = 1'b0;
    #1;
    checkOutput("midResetV",     32'(routerVO[0]), 32'h0);
    checkOutput("midResetBusy",  32'(busy), 32'h0);
    checkOutput("midResetCount", 32'(countO), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2 resetN = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55, 1'b0);
    checkOutput("postResetPassV",    32'(routerVO[0]), 32'h1);
    checkOutput("postResetPassData", routerDataO[W-1:0], 32'h55);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("noStaleV",    32'(routerVO[0]), 32'h0);
    checkOutput("noStaleBusy", 32'(busy[0]), 32'h1);
    tick();
    checkOutput("noStaleCount", 32'(countO[CW-1:0]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_noc_link_loopback.md
BSG_NOC_LINK_LOOPBACK -- requirements
Module: bsg_noc_link_loopback

Interface
REQ-001 Parameter width_p, default 32: flit width in bits.
REQ-002 Parameter channels_p, default 5: number of independent link channels (router directions).
REQ-003 Parameter els_p, default 4: per-channel loopback FIFO depth; power of 2, at least 2.
REQ-004 Parameter count_width_p, default 16: width of each per-channel replay counter.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 mode_i  in  channels_p  per-channel mode request: 0 = pass, 1 = loop.
REQ-008 router_v_i / router_data_i / router_ready_and_o  in/in/out  channels_p / channels_p*width_p / channels_p  flits leaving the router.
REQ-009 router_v_o / router_data_o / router_ready_and_i  out/out/in  channels_p / channels_p*width_p / channels_p  flits entering the router.
REQ-010 ext_v_i / ext_data_i / ext_ready_and_o  in/in/out  channels_p / channels_p*width_p / channels_p  flits arriving from the external link.
REQ-011 ext_v_o / ext_data_o / ext_ready_and_i  out/out/in  channels_p / channels_p*width_p / channels_p  flits sent to the external link.
REQ-012 busy_o  out  channels_p  channel state is not PASS.
REQ-013 count_o  out  channels_p*count_width_p  per-channel replayed-flit count; channel c occupies bits [c*count_width_p +: count_width_p].

Function
REQ-014 Each channel has an independent three-state FSM: PASS, LOOP, DRAIN.
REQ-015 Handshake: a transfer occurs on any port pair in a cycle where both v and ready_and are 1; valid does not depend on ready.
REQ-016 PASS datapath is combinational: ext_v_o = router_v_i, ext_data_o = router_data_i, router_ready_and_o = ext_ready_and_i; router_v_o = ext_v_i, router_data_o = ext_data_i, ext_ready_and_o = router_ready_and_i.
REQ-017 PASS -> LOOP when mode_i = 1 at a clock edge; the FIFO is empty in PASS.
REQ-018 LOOP: ext_v_o = 0 and ext_ready_and_o = 0; router_ready_and_o = FIFO not full; router transfers enqueue router_data_i.
REQ-019 LOOP/DRAIN: router_v_o = FIFO not empty, router_data_o = FIFO head; a router-input transfer dequeues the head.
REQ-020 Minimum loop latency is 1 cycle: a flit enqueued at edge t is presented on router_v_o in cycle t+1.
REQ-021 Full FIFO: router_ready_and_o = 0 even when a dequeue occurs in the same cycle; no bypass.
REQ-022 Simultaneous enqueue and dequeue when the FIFO is neither full nor empty leaves the occupancy unchanged, and FIFO order is preserved.
REQ-023 LOOP -> DRAIN when mode_i = 0; if the FIFO is empty at that edge, LOOP -> PASS directly.
REQ-024 DRAIN: router_ready_and_o = 0, ext_v_o = 0, ext_ready_and_o = 0; replay continues.
REQ-025 DRAIN -> PASS at the edge where the last flit is dequeued.
REQ-026 DRAIN -> LOOP when mode_i returns to 1; FIFO contents are kept.
REQ-027 Read and write pointers are log2(els_p) bits wide, wrap modulo els_p, and use a separate full/empty discriminator bit.
REQ-028 count_o[c] increments on each router-input dequeue in LOOP or DRAIN and saturates at all-ones.
REQ-029 count_o[c] is not cleared by mode changes.
REQ-030 busy_o[c] = 1 in LOOP and DRAIN.
REQ-031 Channels share no state; activity on one channel never affects another.

Reset
REQ-032 On reset_n_i low, immediately and asynchronously: all FSMs go to PASS, FIFOs empty, pointers 0, count_o = 0, busy_o = 0.
REQ-033 After reset, outputs follow the PASS combinational paths.
REQ-034 Reset asserted mid-loop discards all buffered flits; no partial flit is replayed after release.
REQ-035 Reset release is synchronised by the integrator; the block needs only a clean deassertion relative to clk_i.

Verification
REQ-036 Pass mode, channel 0: router_data_i = 0xA5A5A5A5 with v = 1 and ext_ready_and_i = 1 -> ext_data_o = 0xA5A5A5A5 in the same cycle; count_o stays 0.
REQ-037 Loop mode: enqueue 0x1, 0x2, 0x3 with router_ready_and_i = 1 -> router_v_o rises 1 cycle after the first enqueue; output order is 0x1, 0x2, 0x3; count_o[0] = 3.
REQ-038 Full, els_p = 4, router_ready_and_i = 0: after 4 enqueues router_ready_and_o = 0; one dequeue -> router_ready_and_o returns to 1 on the next cycle.
REQ-039 Drain: 2 flits buffered, mode_i drops to 0 -> busy_o stays 1 and router_ready_and_o = 0 until the second dequeue; PASS follows the next cycle.
REQ-040 Saturation, count_width_p = 4: 20 loop replays -> count_o = 0xF.
REQ-041 Reset mid-loop with 3 flits buffered -> router_v_o = 0 and busy_o = 0 immediately; after release, PASS behaviour with no stale flits.
